// File: rtl/button_pkg.sv
// button_pkg: shared channel state type, default timing constants and counter sizing
// Used by: button_channel, button_conditioner (no ports).
package button_pkg;

    typedef enum logic [1:0] {INIT, UP, DOWN} btn_state_t;

    localparam int DEBOUNCE_DEFAULT = 250000;
    localparam int HOLD_DEFAULT     = 12500000;
    localparam int REPEAT_DEFAULT   = 5000000;

    // One counter width is shared by the debounce and repeat counters so both can hold their largest terminal value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: button bus between raw pads, the conditioner and its consumer
// Signals (NUM_BTN bits each):
//   btn_raw       raw pads, 0 = pressed
//   press_ack     consumer clears the matching pending bit
//   btn_level     debounced level, 1 = pressed
//   press_pulse   one-cycle strobe per accepted press
//   press_pending sticky press event
//   overrun       sticky flag: press arrived while still pending
// Modports: master = conditioner side, slave = pad/consumer side.
interface button_conditioner_if #(parameter int NUM_BTN = 4);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press_ack;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] press_pending;
    logic [NUM_BTN-1:0] overrun;

    modport master (input btn_raw, press_ack, output btn_level, press_pulse, press_pending, overrun);
    modport slave (output btn_raw, press_ack, input btn_level, press_pulse, press_pending, overrun);

endinterface

// File: rtl/button_channel.sv
// button_channel: one button (synchronizer, INIT/UP/DOWN debounce FSM, pending/overrun flags)
// Ports: clk, rst_n (async active-low), btn_raw (0 = pressed), press_ack,
//        btn_level, press_pulse, press_pending, overrun.
// Optional feature: define BUTTON_AUTOREPEAT_EN for hold-to-repeat pulses.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic press_ack,
    output logic btn_level,
    output logic press_pulse,
    output logic press_pending,
    output logic overrun
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic          synced;
    logic          moving;
    logic          accept;
    logic          fire;

    assign synced = ~sync[1];
    // INIT and DOWN wait for a released level, UP waits for a pressed one.
    assign moving = (state == UP) ? synced : ~synced;
    assign accept = moving && cnt == DEB;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] rcnt;
    logic          rep;

    // A release accepted on the same edge wins over a repeat.
    assign fire = state == DOWN && !accept && rcnt == (rep ? RPT_LAST : HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            rep  <= 1'b0;
        end else if (state != DOWN || fire) begin
            rcnt <= '0;
            rep  <= state == DOWN;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= 2'b11;
            state       <= INIT;
            cnt         <= '0;
            btn_level   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync        <= {sync[0], btn_raw};
            cnt         <= (moving && !accept) ? cnt + 1'b1 : '0;
            press_pulse <= (state == UP && accept) || fire;
            if (accept) begin
                state     <= (state == UP) ? DOWN : UP;
                btn_level <= state == UP;
            end
        end
    end

    // A coincident ack and pulse leaves the event pending without flagging an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pending <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            press_pending <= press_pulse || (press_pending && !press_ack);
            overrun       <= !press_ack && (overrun || (press_pulse && press_pending));
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_BTN independent debounced button channels on one bus
// Ports: clk, rst_n (async active-low), bus (button_conditioner_if.master).
// Optional feature: define BUTTON_AUTOREPEAT_EN for hold-to-repeat pulses.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    button_conditioner_if.master bus
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pulse;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] ovr;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_raw      (bus.btn_raw[i]),
            .press_ack    (bus.press_ack[i]),
            .btn_level    (level[i]),
            .press_pulse  (pulse[i]),
            .press_pending(pending[i]),
            .overrun      (ovr[i])
        );
    end

    assign bus.btn_level     = level;
    assign bus.press_pulse   = pulse;
    assign bus.press_pending = pending;
    assign bus.overrun       = ovr;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner (DEBOUNCE=8, HOLD=40, REPEAT=16)
module tb_button_conditioner;

    localparam int D = 8;
    localparam int H = 40;
    localparam int R = 16;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    button_conditioner_if #(.NUM_BTN(4)) bus ();

    button_conditioner #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse expected dc edges from now; a press driven now is first sampled on the next edge.
    task automatic expect_pulse(input int dc, input logic [3:0] v);
        q.push_back('{cyc + dc, v});
    endtask

    task automatic ack(input logic [3:0] m);
        bus.press_ack = m;
        step(1);
        bus.press_ack = 4'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.press_pulse !== 4'b0) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {28'b0, bus.press_pulse}, 32'h0);
                end else begin
                    e = q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_vec", {28'b0, bus.press_pulse}, {28'b0, e.v});
                end
            end
        end
    end

    initial begin
        bus.btn_raw   = 4'b1011;
        bus.press_ack = 4'b0;
        step(3);
        check("rst_level", bus.btn_level, 0);
        check("rst_pulse", bus.press_pulse, 0);
        check("rst_pending", bus.press_pending, 0);
        check("rst_overrun", bus.overrun, 0);
        rst_n = 1'b1;
        step(20);
        check("init_level", bus.btn_level, 0);

        bus.btn_raw[0] = 1'b0;
        expect_pulse(D + 3, 4'b0001);
        step(12);
        check("press_level", bus.btn_level[0], 1);
        check("press_pending", bus.press_pending[0], 1);
        bus.btn_raw[0] = 1'b1;
        step(15);
        check("release_level", bus.btn_level[0], 0);
        ack(4'b0001);
        check("ack_clear", bus.press_pending[0], 0);

        bus.btn_raw[1] = 1'b0;
        step(7);
        bus.btn_raw[1] = 1'b1;
        step(15);
        check("glitch_level", bus.btn_level[1], 0);
        check("glitch_pending", bus.press_pending[1], 0);

        check("held_pending", bus.press_pending[2], 0);
        check("held_level", bus.btn_level[2], 0);
        bus.btn_raw[2] = 1'b1;
        step(15);
        bus.btn_raw[2] = 1'b0;
        expect_pulse(D + 3, 4'b0100);
        step(15);
        check("repress_level", bus.btn_level[2], 1);
        bus.btn_raw[2] = 1'b1;
        step(15);
        ack(4'b0100);

        for (int k = 0; k < 2; k++) begin
            bus.btn_raw[3] = 1'b0;
            expect_pulse(D + 3, 4'b1000);
            step(15);
            bus.btn_raw[3] = 1'b1;
            step(15);
        end
        check("ovr_pending", bus.press_pending[3], 1);
        check("ovr_overrun", bus.overrun[3], 1);
        ack(4'b1000);
        check("ack_pending", bus.press_pending[3], 0);
        check("ack_overrun", bus.overrun[3], 0);
        bus.btn_raw[3] = 1'b0;
        expect_pulse(D + 3, 4'b1000);
        step(15);
        bus.btn_raw[3] = 1'b1;
        step(15);
        bus.btn_raw[3] = 1'b0;
        expect_pulse(D + 3, 4'b1000);
        step(D + 3);
        bus.press_ack = 4'b1000;
        step(1);
        bus.press_ack = 4'b0;
        check("coinc_pending", bus.press_pending[3], 1);
        check("coinc_overrun", bus.overrun[3], 0);
        bus.btn_raw[3] = 1'b1;
        step(15);
        ack(4'b1000);

        bus.btn_raw = 4'b0000;
        expect_pulse(D + 3, 4'b1111);
        step(15);
        check("all_level", bus.btn_level, 4'hf);
        check("all_pending", bus.press_pending, 4'hf);
        bus.btn_raw = 4'b1111;
        step(15);
        ack(4'b1111);
        check("all_cleared", bus.press_pending, 0);

        bus.btn_raw[0] = 1'b0;
        expect_pulse(D + 3, 4'b0001);
`ifdef BUTTON_AUTOREPEAT_EN
        expect_pulse(D + 3 + H, 4'b0001);
        expect_pulse(D + 3 + H + R, 4'b0001);
        expect_pulse(D + 3 + H + 2 * R, 4'b0001);
        expect_pulse(D + 3 + H + 3 * R, 4'b0001);
`endif
        step(100);
        check("hold_level", bus.btn_level[0], 1);
        bus.btn_raw[0] = 1'b1;
        step(15);
        check("hold_release", bus.btn_level[0], 0);
`ifdef BUTTON_AUTOREPEAT_EN
        check("hold_overrun", bus.overrun[0], 1);
`else
        check("hold_overrun", bus.overrun[0], 0);
`endif
        step(5);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, stable-level cycles required before a level is accepted (10 ms at 25 MHz).
REQ-003 SHALL have parameters HOLD_CYCLES (default 12500000) and REPEAT_CYCLES (default 5000000), used only by autorepeat.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1, the game clock; reset input 1, asynchronous, active-low.
REQ-005 SHALL have btn_raw, input, NUM_BTN bits: raw asynchronous buttons, 0 = pressed.
REQ-006 SHALL have btn_level, output, NUM_BTN bits: debounced level, 1 = pressed.
REQ-007 SHALL have press_pulse, output, NUM_BTN bits: a one-cycle strobe per accepted press.
REQ-008 SHALL have press_pending, output, NUM_BTN bits: a sticky press event per channel.
REQ-009 SHALL have press_ack, input, NUM_BTN bits: the consumer clears the matching pending bit.
REQ-010 SHALL have overrun, output, NUM_BTN bits: a sticky flag set when a press arrives while that channel is still pending.

Function
REQ-011 SHALL sample each btn_raw bit through a 2-flop synchronizer, then invert it to the active-high synced level.
REQ-012 SHALL run an independent per-channel FSM with states INIT, UP, DOWN. Counter width is $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1).
REQ-013 SHALL make the debounce counter count consecutive cycles in which the synced level differs from the accepted level, and clear it to 0 on any cycle the two agree.
REQ-014 SHALL accept a new level when the counter reaches DEBOUNCE_CYCLES.
REQ-015 SHALL define the latency: if btn_raw goes low and stays low, press_pulse is high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it low.
REQ-016 SHALL make the transitions: INIT→UP after DEBOUNCE_CYCLES of synced level released; UP→DOWN on an accepted press; DOWN→UP on an accepted release.
REQ-017 SHALL emit no press_pulse in INIT, so a button held through reset produces no event until it has been released and pressed again.
REQ-018 SHALL drive btn_level to 1 only in DOWN.
REQ-019 SHALL assert press_pulse for exactly one cycle on the UP→DOWN transition, and never on release.
REQ-020 SHALL set press_pending on press_pulse and clear it on press_ack. When press_ack and press_pulse coincide on a channel, pending stays 1 and overrun is not set.
REQ-021 SHALL set overrun when press_pulse occurs while pending=1 and press_ack=0, and clear it on press_ack.
REQ-022 SHALL ignore press_ack on a non-pending channel.
REQ-023 SHALL discard a glitch shorter than DEBOUNCE_CYCLES with no output change; the counter restarts from 0 on the next disagreement.
REQ-024 SHALL keep all channels fully independent, so simultaneous presses on several channels each pulse in the same cycle.

Reset
REQ-025 SHALL, while reset=0, force synchronizer flops to 1 (released), FSMs to INIT, counters to 0, and btn_level, press_pulse, press_pending and overrun to 0.
REQ-026 SHALL abandon any in-progress debounce on reset asserted mid-operation, with no pulse emitted after release of reset.

Configuration
REQ-027 SHALL, with BUTTON_AUTOREPEAT_EN defined, emit an extra press_pulse (with pending/overrun rules applied) after a channel has stayed in DOWN for HOLD_CYCLES, then every REPEAT_CYCLES while still DOWN; the repeat counter resets on entry to DOWN.
REQ-028 SHALL, without BUTTON_AUTOREPEAT_EN, emit exactly one press_pulse per press; HOLD_CYCLES and REPEAT_CYCLES are unused and no repeat logic is synthesized.

Structure
REQ-029 SHALL place the FSM state enum (INIT, UP, DOWN) and default DEBOUNCE/HOLD/REPEAT constants in shared package button_pkg.
REQ-030 SHALL implement one channel (synchronizer, FSM, counters, pending/overrun) as sub-module button_channel, instantiated NUM_BTN times by a generate loop.

Verification (DEBOUNCE_CYCLES=8, HOLD_CYCLES=40, REPEAT_CYCLES=16 in sim)
REQ-031 SHALL test clean press: btn_raw[0] held high 20 cycles then low → press_pulse[0] high exactly on edge 11 after first low sample, btn_level[0]=1, press_pending[0]=1.
REQ-032 SHALL test a glitch: btn_raw[1] low for 7 cycles, then high → no press_pulse, btn_level[1]=0, pending 0.
REQ-033 SHALL test reset while held: btn_raw[2] low across reset release → no pulse while held; after release ≥8 cycles and re-press, exactly one pulse.
REQ-034 SHALL test pending handshake: two presses on ch3 without ack → pending=1, overrun=1; press_ack[3] → both 0; ack coinciding with a pulse → pending=1, overrun=0.
REQ-035 SHALL test simultaneous presses: all four btn_raw fall in the same cycle → press_pulse=4'b1111 for one cycle.
REQ-036 SHALL test autorepeat with BUTTON_AUTOREPEAT_EN: ch0 held for 100 cycles after acceptance → repeat pulses at DOWN-cycles 40, 56, 72, 88; without the macro → a single pulse only.
